// File: rtl/id_stage_pipelined.sv
// LEGv8 decode stage: register file, control decode, immediate generation,
// load-use / CBZ hazard detection, early branch resolution and the ID/EX register.
module id_stage_pipelined #(
  parameter int   DATA_W       = 64,
  parameter logic BYPASS       = 1'b1,
  parameter logic EARLY_BRANCH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_ready,
  input  logic              ex_stall,
  input  logic              exmem_regwrite,
  input  logic [4:0]        exmem_rd,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              idex_valid,
  output logic [8:0]        idex_ctrl,
  output logic [DATA_W-1:0] idex_rd1,
  output logic [DATA_W-1:0] idex_rd2,
  output logic [DATA_W-1:0] idex_imm,
  output logic [DATA_W-1:0] idex_pc,
  output logic [4:0]        idex_rn,
  output logic [4:0]        idex_rm,
  output logic [4:0]        idex_rd,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              if_flush
);

  typedef struct packed {
    logic              valid;
    logic [8:0]        ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [4:0]        rd;
  } idex_t;

  logic [DATA_W-1:0] rf_q [32];
  idex_t             idex_q, idex_d;

  logic [10:0]       opc;
  logic              is_r, is_ldur, is_stur, is_cbz, is_b, uses_rm;
  logic [4:0]        rn_addr, rm_addr, rd_addr;
  logic [DATA_W-1:0] rd1_data, rd2_data, imm;
  logic [8:0]        ctrl;
  logic              load_use, cbz_hazard, hazard;

  assign opc     = if_instr[31:21];
  assign is_r    = (opc == 11'b10001011000) || (opc == 11'b11001011000) ||
                   (opc == 11'b10001010000) || (opc == 11'b10101010000);
  assign is_ldur = (opc == 11'b11111000010);
  assign is_stur = (opc == 11'b11111000000);
  assign is_cbz  = (opc[10:3] == 8'b10110100);
  assign is_b    = (opc[10:5] == 6'b000101);
  assign uses_rm = is_r | is_stur | is_cbz;

  assign rn_addr = if_instr[9:5];
  assign rm_addr = if_instr[28] ? if_instr[4:0] : if_instr[20:16];
  assign rd_addr = if_instr[4:0];

  // X31 is hard zero; a same-cycle WB write is forwarded only when BYPASS is set
  assign rd1_data = (rn_addr == 5'd31) ? '0 :
                    (BYPASS && wb_en && (wb_addr == rn_addr)) ? wb_data : rf_q[rn_addr];
  assign rd2_data = (rm_addr == 5'd31) ? '0 :
                    (BYPASS && wb_en && (wb_addr == rm_addr)) ? wb_data : rf_q[rm_addr];

  always_comb begin
    ctrl = '0;
    imm  = '0;
    if (is_r) begin
      ctrl = 9'b1_0000_10_0_0;
    end else if (is_ldur) begin
      ctrl = 9'b1_1011_00_0_0;
      imm  = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
    end else if (is_stur) begin
      ctrl = 9'b0_0101_00_0_0;
      imm  = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
    end else if (is_cbz) begin
      ctrl = 9'b0_0000_01_1_0;
      imm  = {{(DATA_W-21){if_instr[23]}}, if_instr[23:5], 2'b00};
    end else if (is_b) begin
      ctrl = 9'b0_0000_00_0_1;
      imm  = {{(DATA_W-28){if_instr[25]}}, if_instr[25:0], 2'b00};
    end
  end

  assign load_use = if_valid && idex_q.valid && idex_q.ctrl[7] && (idex_q.rd != 5'd31) &&
                    ((!is_b && (idex_q.rd == rn_addr)) || (uses_rm && (idex_q.rd == rm_addr)));

  // CBZ compares in ID, so its operand must not still be in flight in EX or MEM
  assign cbz_hazard = EARLY_BRANCH && if_valid && is_cbz && (rm_addr != 5'd31) &&
                      ((idex_q.valid && idex_q.ctrl[8] && (idex_q.rd == rm_addr)) ||
                       (exmem_regwrite && (exmem_rd == rm_addr)));

  assign hazard        = load_use | cbz_hazard;
  assign id_ready      = !ex_stall && !hazard;
  assign branch_taken  = EARLY_BRANCH && if_valid && id_ready &&
                         (is_b || (is_cbz && (rd2_data == '0)));
  assign branch_target = if_pc + imm;
  assign if_flush      = branch_taken;

  always_comb begin
    idex_d = idex_q;
    if (ex_stall) begin
      idex_d = idex_q;
    end else if (hazard) begin
      idex_d = '0;
    end else begin
      idex_d.valid = if_valid;
      idex_d.ctrl  = ctrl;
      idex_d.rd1   = rd1_data;
      idex_d.rd2   = rd2_data;
      idex_d.imm   = imm;
      idex_d.pc    = if_pc;
      idex_d.rn    = rn_addr;
      idex_d.rm    = rm_addr;
      idex_d.rd    = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd31)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign idex_valid = idex_q.valid;
  assign idex_ctrl  = idex_q.ctrl;
  assign idex_rd1   = idex_q.rd1;
  assign idex_rd2   = idex_q.rd2;
  assign idex_imm   = idex_q.imm;
  assign idex_pc    = idex_q.pc;
  assign idex_rn    = idex_q.rn;
  assign idex_rm    = idex_q.rm;
  assign idex_rd    = idex_q.rd;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural decode-stage model.
module tb_id_stage_pipelined;

  localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000,
                          OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000,
                          OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000;
  localparam logic [8:0]  C_R = 9'h108, C_LD = 9'h1B0, C_ST = 9'h050, C_CBZ = 9'h006, C_B = 9'h001;

  logic clk = 1'b0, reset, if_valid, ex_stall, exmem_regwrite, wb_en;
  logic [31:0] if_instr;
  logic [63:0] if_pc, wb_data;
  logic [4:0]  exmem_rd, wb_addr;

  logic id_ready, idex_valid, branch_taken, if_flush;
  logic [8:0] idex_ctrl;
  logic [63:0] idex_rd1, idex_rd2, idex_imm, idex_pc, branch_target;
  logic [4:0] idex_rn, idex_rm, idex_rd;

  logic b0_id_ready, b0_idex_valid, b0_branch_taken, b0_if_flush;
  logic [8:0] b0_idex_ctrl;
  logic [63:0] b0_idex_rd1, b0_idex_rd2, b0_idex_imm, b0_idex_pc, b0_branch_target;
  logic [4:0] b0_idex_rn, b0_idex_rm, b0_idex_rd;

  always #5 clk = ~clk;

  id_stage_pipelined #(.DATA_W(64), .BYPASS(1'b1), .EARLY_BRANCH(1'b1)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .ex_stall(ex_stall), .exmem_regwrite(exmem_regwrite),
    .exmem_rd(exmem_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .idex_valid(idex_valid), .idex_ctrl(idex_ctrl), .idex_rd1(idex_rd1), .idex_rd2(idex_rd2),
    .idex_imm(idex_imm), .idex_pc(idex_pc), .idex_rn(idex_rn), .idex_rm(idex_rm),
    .idex_rd(idex_rd), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_flush(if_flush));

  id_stage_pipelined #(.DATA_W(64), .BYPASS(1'b0), .EARLY_BRANCH(1'b1)) dut_nobyp (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(b0_id_ready), .ex_stall(ex_stall), .exmem_regwrite(exmem_regwrite),
    .exmem_rd(exmem_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .idex_valid(b0_idex_valid), .idex_ctrl(b0_idex_ctrl), .idex_rd1(b0_idex_rd1),
    .idex_rd2(b0_idex_rd2), .idex_imm(b0_idex_imm), .idex_pc(b0_idex_pc),
    .idex_rn(b0_idex_rn), .idex_rm(b0_idex_rm), .idex_rd(b0_idex_rd),
    .branch_taken(b0_branch_taken), .branch_target(b0_branch_target), .if_flush(b0_if_flush));

  typedef struct {
    logic valid; logic [8:0] ctrl;
    logic [63:0] rd1, rd2, imm, pc;
    logic [4:0] rn, rm, rd;
  } mi_t;

  logic [63:0] m_regs [32];
  mi_t m_idex;
  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic mi_t mi_zero();
    mi_t z;
    z.valid = 0; z.ctrl = 0; z.rd1 = 0; z.rd2 = 0; z.imm = 0; z.pc = 0;
    z.rn = 0; z.rm = 0; z.rd = 0;
    return z;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_idex = mi_zero();
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [8:0] m_ctrl(input logic [31:0] ins);
    logic [10:0] op = ins[31:21];
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return C_R;
    if (op == OP_LDUR) return C_LD;
    if (op == OP_STUR) return C_ST;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op[10:5] == 6'b000101) return C_B;
    return 9'd0;
  endfunction

  function automatic logic [63:0] m_imm(input logic [31:0] ins);
    logic signed [8:0]  d9  = ins[20:12];
    logic signed [18:0] c19 = ins[23:5];
    logic signed [25:0] b26 = ins[25:0];
    logic [8:0] c = m_ctrl(ins);
    if (c == C_LD || c == C_ST) return longint'(d9);
    if (c == C_CBZ) return longint'(c19) * 4;
    if (c == C_B) return longint'(b26) * 4;
    return 64'd0;
  endfunction

  // One clock of the model: combinational checks before the edge, ID/EX checks after it.
  task automatic cyc();
    logic [8:0] c;
    logic [4:0] rn, r2;
    logic lu, cz, e_ready, e_taken;
    mi_t nx;
    #1;
    c  = m_ctrl(if_instr);
    rn = if_instr[9:5];
    r2 = if_instr[28] ? if_instr[4:0] : if_instr[20:16];
    lu = if_valid && m_idex.valid && m_idex.ctrl == C_LD && m_idex.rd != 5'd31 &&
         ((c != C_B && m_idex.rd == rn) || ((c == C_R || c == C_ST || c == C_CBZ) && m_idex.rd == r2));
    cz = if_valid && c == C_CBZ && r2 != 5'd31 &&
         ((m_idex.valid && (m_idex.ctrl == C_R || m_idex.ctrl == C_LD) && m_idex.rd == r2) ||
          (exmem_regwrite && exmem_rd == r2));
    e_ready = !ex_stall && !lu && !cz;
    e_taken = if_valid && e_ready && (c == C_B || (c == C_CBZ && m_read(r2) == 64'd0));
    chk("id_ready", id_ready, e_ready);
    chk("branch_taken", branch_taken, e_taken);
    chk("if_flush", if_flush, e_taken);
    if (e_taken) chk("branch_target", branch_target, if_pc + m_imm(if_instr));
    if (ex_stall) nx = m_idex;
    else if (lu || cz) nx = mi_zero();
    else begin
      nx.valid = if_valid; nx.ctrl = c; nx.rd1 = m_read(rn); nx.rd2 = m_read(r2);
      nx.imm = m_imm(if_instr); nx.pc = if_pc; nx.rn = rn; nx.rm = r2; nx.rd = if_instr[4:0];
    end
    @(posedge clk);
    m_idex = nx;
    if (wb_en && wb_addr != 5'd31) m_regs[wb_addr] = wb_data;
    #1;
    chk("idex_valid", idex_valid, m_idex.valid);
    chk("idex_ctrl", idex_ctrl, m_idex.ctrl);
    chk("idex_rd1", idex_rd1, m_idex.rd1);
    chk("idex_rd2", idex_rd2, m_idex.rd2);
    chk("idex_imm", idex_imm, m_idex.imm);
    chk("idex_pc", idex_pc, m_idex.pc);
    chk("idex_rn", idex_rn, m_idex.rn);
    chk("idex_rm", idex_rm, m_idex.rm);
    chk("idex_rd", idex_rd, m_idex.rd);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic we, input logic [4:0] wa, input logic [63:0] wd);
    if_valid = v; if_instr = ins; if_pc = pc; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, rn, rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] im,
                                        input logic [4:0] rn, rt);
    return {op, im, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_cbz(input logic [18:0] im, input logic [4:0] rt);
    return {8'b10110100, im, rt};
  endfunction

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [10:0] rops [4] = '{OP_ADD, OP_SUB, OP_AND, OP_ORR};
    logic [31:0] junk = $urandom();
    case ($urandom_range(0, 6))
      0, 6: return enc_r(rops[$urandom_range(0, 3)], rreg(), rreg(), rreg());
      1: return enc_d(OP_LDUR, 9'($urandom()), rreg(), rreg());
      2: return enc_d(OP_STUR, 9'($urandom()), rreg(), rreg());
      3: return enc_cbz(19'($urandom()), rreg());
      4: return {6'b000101, junk[25:0]};
      default: return junk;
    endcase
  endfunction

  initial begin
    reset = 1'b0; ex_stall = 0; exmem_regwrite = 0; exmem_rd = 0;
    set_in(0, 32'd0, 64'd0, 0, 5'd0, 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst idex_valid", idex_valid, 1'b0);
    chk("rst idex_ctrl", idex_ctrl, 9'd0);
    chk("rst idex_rd1", idex_rd1, 64'd0);
    chk("rst id_ready", id_ready, 1'b1);
    chk("rst branch_taken", branch_taken, 1'b0);
    reset = 1'b1;

    // write X3, then ADD X5,X3,X3
    set_in(0, 32'd0, 64'd0, 1, 5'd3, 64'h1234); cyc();
    set_in(1, enc_r(OP_ADD, 5'd3, 5'd3, 5'd5), 64'h40, 0, 5'd0, 64'd0); cyc();
    chk("add rd1", idex_rd1, 64'h1234);
    chk("add rd2", idex_rd2, 64'h1234);
    chk("add ctrl", idex_ctrl, 9'h108);
    chk("add valid", idex_valid, 1'b1);

    // same-cycle write/read of X7
    set_in(1, enc_r(OP_ADD, 5'd7, 5'd7, 5'd8), 64'h44, 1, 5'd7, 64'hAA); cyc();
    chk("bypass rd1", idex_rd1, 64'hAA);
    chk("nobypass rd1", b0_idex_rd1, 64'h0);

    // LDUR X2,[X1,#8] then dependent ADD
    set_in(1, enc_d(OP_LDUR, 9'd8, 5'd1, 5'd2), 64'h48, 0, 5'd0, 64'd0); cyc();
    chk("ldur imm", idex_imm, 64'd8);
    chk("ldur ctrl", idex_ctrl, 9'h1B0);
    set_in(1, enc_r(OP_ADD, 5'd2, 5'd2, 5'd4), 64'h4C, 0, 5'd0, 64'd0);
    #1 chk("lu id_ready", id_ready, 1'b0);
    cyc();
    chk("lu bubble", idex_valid, 1'b0);
    cyc();
    chk("lu resume", idex_valid, 1'b1);

    // CBZ X9,#-4 with X9=0 and then X9=5
    set_in(0, 32'd0, 64'd0, 0, 5'd0, 64'd0); cyc();
    set_in(1, enc_cbz(19'h7FFFC, 5'd9), 64'h100, 0, 5'd0, 64'd0);
    #1 chk("cbz taken", branch_taken, 1'b1);
    chk("cbz target", branch_target, 64'hF0);
    chk("cbz flush", if_flush, 1'b1);
    cyc();
    set_in(0, 32'd0, 64'd0, 1, 5'd9, 64'd5); cyc();
    set_in(1, enc_cbz(19'h7FFFC, 5'd9), 64'h100, 0, 5'd0, 64'd0);
    #1 chk("cbz nz", branch_taken, 1'b0);
    cyc();

    // ADD X9 then CBZ X9: two stalls, then resolve on bypassed WB value
    set_in(1, enc_r(OP_ADD, 5'd1, 5'd1, 5'd9), 64'h1F0, 0, 5'd0, 64'd0); cyc();
    set_in(1, enc_cbz(19'd4, 5'd9), 64'h200, 0, 5'd0, 64'd0);
    #1 chk("cbz st1", id_ready, 1'b0);
    cyc();
    exmem_regwrite = 1; exmem_rd = 5'd9;
    #1 chk("cbz st2", id_ready, 1'b0);
    cyc();
    exmem_regwrite = 0; set_in(1, enc_cbz(19'd4, 5'd9), 64'h200, 1, 5'd9, 64'd0);
    #1 chk("cbz wb ready", id_ready, 1'b1);
    chk("cbz wb taken", branch_taken, 1'b1);
    chk("cbz wb target", branch_target, 64'h210);
    cyc();

    // ex_stall during load-use, then async reset mid-stall
    set_in(1, enc_d(OP_LDUR, 9'd8, 5'd1, 5'd2), 64'h300, 0, 5'd0, 64'd0); cyc();
    set_in(1, enc_r(OP_ADD, 5'd2, 5'd2, 5'd4), 64'h304, 0, 5'd0, 64'd0);
    ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall hold pc", idex_pc, 64'h300);
      chk("stall hold valid", idex_valid, 1'b1);
    end
    #2 reset = 1'b0;
    #1 chk("async rst valid", idex_valid, 1'b0);
    chk("async rst pc", idex_pc, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1; ex_stall = 0;
    set_in(1, enc_r(OP_ADD, 5'd7, 5'd3, 5'd5), 64'h400, 0, 5'd0, 64'd0); cyc();
    chk("rst x3", idex_rd1, 64'd0);
    chk("rst x7", idex_rd2, 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if_valid = ($urandom_range(0, 9) < 8);
      if_instr = rand_instr();
      if_pc = {$urandom(), $urandom()};
      ex_stall = ($urandom_range(0, 99) < 15);
      exmem_regwrite = $urandom_range(0, 1);
      exmem_rd = rreg();
      wb_en = $urandom_range(0, 1);
      wb_addr = rreg();
      wb_data = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()};
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
